// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types for the ALU sequencer: operator encoding,
//               operator class helpers and the buffered-op entry record.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned REG_AW  = 5;
   localparam int unsigned SHAMT_W = 5;

   typedef enum logic [3:0] {
      ADD, SUB, SRA, SRL, SLL, XOR, OR, AND,
      SLT, LT, SLTU, LTU, GE, GEU, EQ, NE
   } alu_op;

   typedef struct packed {
      alu_op               op;
      logic [XLEN-1:0]     a;
      logic [XLEN-1:0]     b;
      logic [REG_AW-1:0]   rd;
   } alu_seq_entry_t;

   // Shifts only honour the low five bits of operand B
   function automatic logic is_shift(input alu_op op);
      return op inside {SLL, SRL, SRA};
   endfunction

   // Set-on-compare ops write a 0/1 value to the register file
   function automatic logic is_setcmp(input alu_op op);
      return op inside {SLT, SLTU};
   endfunction

   // Branch compares produce a condition only, no register write
   function automatic logic is_branch(input alu_op op);
      return op inside {LT, LTU, GE, GEU, EQ, NE};
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_fifo
// Description : Synchronous FIFO of decoded ALU operations. Push and pop may
//               share an edge, including while full.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_fifo
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           push_i,
   input  alu_seq_entry_t push_data_i,
   output logic           full_o,
   input  logic           pop_i,
   output alu_seq_entry_t pop_data_o,
   output logic           empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   // Pointers carry one wrap bit to tell full from empty
   logic [AW:0]    wptr_q, wptr_d;
   logic [AW:0]    rptr_q, rptr_d;
   alu_seq_entry_t mem_q [DEPTH];
   alu_seq_entry_t mem_d [DEPTH];
   logic           do_push;
   logic           do_pop;

   assign empty_o    = (wptr_q == rptr_q);
   assign full_o     = (wptr_q[AW] != rptr_q[AW]) &&
                       (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_pop     = pop_i && !empty_o;
   assign do_push    = push_i && (!full_o || do_pop);
   assign pop_data_o = mem_q[rptr_q[AW-1:0]];

   // Next storage and pointer values for this edge's push/pop
   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) begin
         mem_d[wptr_q[AW-1:0]] = push_data_i;
         wptr_d                = wptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
         rptr_d = rptr_q + (AW+1)'(1);
      end
   end

   // Storage and pointer registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         mem_q  <= '{default: '0};
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         mem_q  <= mem_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Issues decoded ops to the ALU with a one-cycle request pulse,
//               waits a fixed settle time, normalises the result and hands it
//               to writeback. Define ALU_SEQ_OPBUF_EN to place a FIFO_DEPTH
//               entry op buffer in front of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned FIFO_DEPTH    = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  alu_op             in_op_i,
   input  logic [XLEN-1:0]   in_a_i,
   input  logic [XLEN-1:0]   in_b_i,
   input  logic [REG_AW-1:0] in_rd_i,
   output logic              req_o,
   output alu_op             operator_o,
   output logic [XLEN-1:0]   op_a_o,
   output logic [XLEN-1:0]   op_b_o,
   input  logic [XLEN-1:0]   result_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [XLEN-1:0]   out_data_o,
   output logic [REG_AW-1:0] out_rd_o,
   output logic              out_we_o,
   output logic              out_branch_o
);

   localparam int unsigned      CNT_W    = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("alu_sequencer: SETTLE_CYCLES must be at least 1");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("alu_sequencer: FIFO_DEPTH must be a power of two, at least 2");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t              state_q,      state_d;
   logic [CNT_W-1:0]    cnt_q,        cnt_d;
   alu_op               operator_q,   operator_d;
   logic [XLEN-1:0]     op_a_q,       op_a_d;
   logic [XLEN-1:0]     op_b_q,       op_b_d;
   logic [REG_AW-1:0]   rd_q,         rd_d;
   logic                setcmp_q,     setcmp_d;
   logic                branch_q,     branch_d;
   logic [XLEN-1:0]     out_data_q,   out_data_d;
   logic [REG_AW-1:0]   out_rd_q,     out_rd_d;
   logic                out_we_q,     out_we_d;
   logic                out_branch_q, out_branch_d;

   alu_seq_entry_t      in_entry;
   alu_seq_entry_t      src_entry;
   logic                src_valid;
   logic                load;

   assign in_entry = '{op: in_op_i, a: in_a_i, b: in_b_i, rd: in_rd_i};

`ifdef ALU_SEQ_OPBUF_EN
   logic fifo_full;
   logic fifo_empty;

   alu_seq_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (in_valid_i && in_ready_o),
      .push_data_i (in_entry),
      .full_o      (fifo_full),
      .pop_i       (load),
      .pop_data_o  (src_entry),
      .empty_o     (fifo_empty)
   );

   assign src_valid  = !fifo_empty;
   assign in_ready_o = !fifo_full;
`else
   // Without a buffer, ops go straight into the operand registers
   assign src_entry  = in_entry;
   assign src_valid  = in_valid_i;
   assign in_ready_o = (state_q == IDLE) || ((state_q == HOLD) && out_ready_i);
`endif

   assign req_o        = (state_q == ISSUE);
   assign out_valid_o  = (state_q == HOLD);
   assign operator_o   = operator_q;
   assign op_a_o       = op_a_q;
   assign op_b_o       = op_b_q;
   assign out_data_o   = out_data_q;
   assign out_rd_o     = out_rd_q;
   assign out_we_o     = out_we_q;
   assign out_branch_o = out_branch_q;

   // Next-state, operand load and result capture
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      operator_d   = operator_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      rd_d         = rd_q;
      setcmp_d     = setcmp_q;
      branch_d     = branch_q;
      out_data_d   = out_data_q;
      out_rd_d     = out_rd_q;
      out_we_d     = out_we_q;
      out_branch_d = out_branch_q;
      load         = 1'b0;

      case (state_q)
         IDLE: begin
            load = src_valid;
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == CNT_ONE) begin
               out_rd_d = rd_q;
               if (branch_q) begin
                  out_data_d   = '0;
                  out_we_d     = 1'b0;
                  out_branch_d = result_i[XLEN-1];
               end else if (setcmp_q) begin
                  out_data_d   = {{(XLEN-1){1'b0}}, result_i[XLEN-1]};
                  out_we_d     = 1'b1;
                  out_branch_d = 1'b0;
               end else begin
                  out_data_d   = result_i;
                  out_we_d     = 1'b1;
                  out_branch_d = 1'b0;
               end
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         HOLD: begin
            if (out_ready_i) begin
               state_d = IDLE;
               load    = src_valid;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Operand registers only change on a load from IDLE or HOLD
      if (load) begin
         operator_d = src_entry.op;
         op_a_d     = src_entry.a;
         op_b_d     = is_shift(src_entry.op) ?
                      {{(XLEN-SHAMT_W){1'b0}}, src_entry.b[SHAMT_W-1:0]} :
                      src_entry.b;
         rd_d       = src_entry.rd;
         setcmp_d   = is_setcmp(src_entry.op);
         branch_d   = is_branch(src_entry.op);
         cnt_d      = CNT_LOAD;
         state_d    = ISSUE;
      end
   end

   // State, operand and result registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         operator_q   <= ADD;
         op_a_q       <= '0;
         op_b_q       <= '0;
         rd_q         <= '0;
         setcmp_q     <= 1'b0;
         branch_q     <= 1'b0;
         out_data_q   <= '0;
         out_rd_q     <= '0;
         out_we_q     <= 1'b0;
         out_branch_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         operator_q   <= operator_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         rd_q         <= rd_d;
         setcmp_q     <= setcmp_d;
         branch_q     <= branch_d;
         out_data_q   <= out_data_d;
         out_rd_q     <= out_rd_d;
         out_we_q     <= out_we_d;
         out_branch_q <= out_branch_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer. A stand-in ALU answers
//               the request pulse after the settle time; an op-level model
//               predicts every issue and every result. Honours ALU_SEQ_OPBUF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_sequencer;
   import alu_pkg::*;

   localparam int unsigned S     = 2;
   localparam int unsigned DEPTH = 2;
`ifdef ALU_SEQ_OPBUF_EN
   localparam int LAT     = S + 3;
   localparam int REQ_CYC = 2;
`else
   localparam int LAT     = S + 2;
   localparam int REQ_CYC = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        in_valid_i, in_ready_o, req_o, out_valid_o, out_ready_i;
   alu_op       in_op_i, operator_o;
   logic [31:0] in_a_i, in_b_i, op_a_o, op_b_o, result_i, out_data_o;
   logic [4:0]  in_rd_i, out_rd_o;
   logic        out_we_o, out_branch_o;
   logic        rand_ready = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_sequencer #(.SETTLE_CYCLES(S), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_op_i(in_op_i),
      .in_a_i(in_a_i), .in_b_i(in_b_i), .in_rd_i(in_rd_i),
      .req_o(req_o), .operator_o(operator_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
      .result_i(result_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .out_rd_o(out_rd_o), .out_we_o(out_we_o), .out_branch_o(out_branch_o)
   );

   typedef struct {
      alu_op       op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        we;
      logic        br;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        req_q[$];
   logic [31:0] out_log[$];

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
      end
   endfunction

   // Comparison truth for every compare-class operator
   function automatic logic cond(alu_op op, logic [31:0] a, logic [31:0] b);
      case (op)
         SLT, LT:   return $signed(a) < $signed(b);
         SLTU, LTU: return a < b;
         GE:        return $signed(a) >= $signed(b);
         GEU:       return a >= b;
         EQ:        return a == b;
         NE:        return a != b;
         default:   return 1'b0;
      endcase
   endfunction

   // Plain arithmetic result; shift amount taken at full width
   function automatic logic [31:0] arith(alu_op op, logic [31:0] a, logic [31:0] b);
      case (op)
         ADD:     return a + b;
         SUB:     return a - b;
         SLL:     return a << b;
         SRL:     return a >> b;
         SRA:     return $unsigned($signed(a) >>> b);
         XOR:     return a ^ b;
         OR:      return a | b;
         AND:     return a & b;
         default: return 32'h0;
      endcase
   endfunction

   function automatic exp_t model(alu_op op, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
      exp_t e;
      e.op = op;
      e.a  = a;
      e.b  = (op inside {SLL, SRL, SRA}) ? (b & 32'h1F) : b;
      e.rd = rd;
      e.we = 1'b1;
      e.br = 1'b0;
      if (op inside {SLT, SLTU}) begin
         e.data = cond(op, a, b) ? 32'h1 : 32'h0;
      end else if (op inside {LT, LTU, GE, GEU, EQ, NE}) begin
         e.data = 32'h0;
         e.we   = 1'b0;
         e.br   = cond(op, a, b);
      end else begin
         e.data = arith(op, a, e.b);
      end
      return e;
   endfunction

   // Stand-in ALU: latches on the request pulse, garbage until settled
   alu_op       alu_op_l;
   logic [31:0] alu_a_l, alu_b_l;
   int          settle_cnt = 0;
   function automatic logic [31:0] alu_answer();
      logic [31:0] junk = $urandom;
      if (alu_op_l inside {SLT, SLTU, LT, LTU, GE, GEU, EQ, NE})
         return {cond(alu_op_l, alu_a_l, alu_b_l), junk[30:0]};
      return arith(alu_op_l, alu_a_l, alu_b_l);
   endfunction
   initial begin
      result_i = 32'h0;
      forever begin
         @(posedge clk);
         if (!rst_ni) begin
            settle_cnt = 0;
         end else if (req_o) begin
            alu_op_l   = operator_o;
            alu_a_l    = op_a_o;
            alu_b_l    = op_b_o;
            settle_cnt = S - 1;
            #1;
            result_i = (settle_cnt == 0) ? alu_answer() : $urandom;
         end else if (settle_cnt > 0) begin
            settle_cnt--;
            #1;
            if (settle_cnt == 0) result_i = alu_answer();
         end
      end
   end

   // Random writeback backpressure when enabled
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) out_ready_i = ($urandom_range(0, 3) != 0);
      end
   end

   // Per-cycle comparison against the op-level model
   logic prev_req = 1'b0;
   int   stall = 0;
   always @(negedge clk) begin
      exp_t e;
      logic exp_rdy;
      if (!rst_ni) begin
         chk("rst_req", 32'(req_o), 0);
         chk("rst_out_valid", 32'(out_valid_o), 0);
         chk("rst_out_data", out_data_o, 0);
         chk("rst_out_rd", 32'(out_rd_o), 0);
         chk("rst_out_we", 32'(out_we_o), 0);
         chk("rst_out_branch", 32'(out_branch_o), 0);
         chk("rst_op_a", op_a_o, 0);
         chk("rst_op_b", op_b_o, 0);
         chk("rst_operator", 32'(operator_o), 32'(ADD));
         exp_q.delete();
         req_q.delete();
         prev_req = 1'b0;
         stall    = 0;
      end else begin
`ifdef ALU_SEQ_OPBUF_EN
         exp_rdy = (req_q.size() - (req_o ? 1 : 0)) < DEPTH;
`else
         exp_rdy = (exp_q.size() == 0) || (out_valid_o && out_ready_i);
`endif
         chk("in_ready", 32'(in_ready_o), 32'(exp_rdy));
         if (req_o) begin
            chk("req_single_cycle", 32'(prev_req), 0);
            chk("req_has_op", 32'(req_q.size() != 0), 1);
            if (req_q.size() != 0) begin
               e = req_q[0];
               chk("issue_operator", 32'(operator_o), 32'(e.op));
               chk("issue_op_a", op_a_o, e.a);
               chk("issue_op_b", op_b_o, e.b);
            end
         end
         if (out_valid_o) begin
            chk("out_has_op", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q[0];
               chk("out_data", out_data_o, e.data);
               chk("out_rd", 32'(out_rd_o), 32'(e.rd));
               chk("out_we", 32'(out_we_o), 32'(e.we));
               chk("out_branch", 32'(out_branch_o), 32'(e.br));
               chk("hold_op_a", op_a_o, e.a);
               chk("hold_op_b", op_b_o, e.b);
               chk("hold_operator", 32'(operator_o), 32'(e.op));
            end
         end
         if (exp_q.size() != 0 && !out_valid_o) stall++;
         else stall = 0;
         if (stall > 60) begin
            chk("result_timeout", 32'(stall), 0);
            exp_q.delete();
            req_q.delete();
            stall = 0;
         end
         if (req_o && req_q.size() != 0) void'(req_q.pop_front());
         if (out_valid_o && out_ready_i && exp_q.size() != 0) begin
            out_log.push_back(out_data_o);
            void'(exp_q.pop_front());
         end
         if (in_valid_i && in_ready_o) begin
            e = model(in_op_i, in_a_i, in_b_i, in_rd_i);
            exp_q.push_back(e);
            req_q.push_back(e);
         end
         prev_req = req_o;
      end
   end

   task automatic send(alu_op op, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
      bit acc = 1'b0;
      int guard = 0;
      in_valid_i = 1'b1;
      in_op_i    = op;
      in_a_i     = a;
      in_b_i     = b;
      in_rd_i    = rd;
      while (!acc) begin
         @(negedge clk);
         acc = in_ready_o;
         @(posedge clk);
         #1;
         guard++;
         if (!acc && guard > 200) begin
            chk("send_timeout", 32'(guard), 0);
            break;
         end
      end
      in_valid_i = 1'b0;
   endtask

   task automatic run_one(alu_op op, logic [31:0] a, logic [31:0] b, logic [4:0] rd,
                          logic [31:0] xd, logic xwe, logic xbr, logic [31:0] xopb);
      int lat = 0;
      int reqs = 0;
      int req_at = 0;
      out_ready_i = 1'b1;
      send(op, a, b, rd);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (req_o) begin
            reqs++;
            req_at = k;
            chk("lit_op_b", op_b_o, xopb);
         end
         if (out_valid_o) begin
            lat = k;
            break;
         end
      end
      chk("lit_latency", 32'(lat), 32'(LAT));
      chk("lit_req_cycle", 32'(req_at), 32'(REQ_CYC));
      chk("lit_req_count", 32'(reqs), 1);
      chk("lit_data", out_data_o, xd);
      chk("lit_rd", 32'(out_rd_o), 32'(rd));
      chk("lit_we", 32'(out_we_o), 32'(xwe));
      chk("lit_branch", 32'(out_branch_o), 32'(xbr));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      @(posedge clk);
      #1;
      chk("drain_empty", 32'(exp_q.size()), 0);
   endtask

   task automatic backpressure();
      out_ready_i = 1'b0;
      send(XOR, 32'hA5A5_0000, 32'h0F0F_F0F0, 5'd11);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid_o) break;
      end
`ifdef ALU_SEQ_OPBUF_EN
      send(ADD, 32'd10, 32'd20, 5'd12);
      send(SUB, 32'd10, 32'd20, 5'd13);
      in_valid_i = 1'b1;
      in_op_i    = OR;
      in_a_i     = 32'd1;
      in_b_i     = 32'd2;
      in_rd_i    = 5'd14;
`endif
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_valid", 32'(out_valid_o), 1);
         chk("bp_data", out_data_o, 32'hAAAA_F0F0);
         chk("bp_rd", 32'(out_rd_o), 11);
         chk("bp_op_a", op_a_o, 32'hA5A5_0000);
`ifdef ALU_SEQ_OPBUF_EN
         chk("bp_full_stall", 32'(in_ready_o), 0);
`endif
      end
      out_log.delete();
      @(posedge clk);
      #1;
      out_ready_i = 1'b1;
`ifdef ALU_SEQ_OPBUF_EN
      send(OR, 32'd1, 32'd2, 5'd14);
`endif
      drain();
`ifdef ALU_SEQ_OPBUF_EN
      chk("bp_count", 32'(out_log.size()), 4);
      if (out_log.size() == 4) begin
         chk("bp_order0", out_log[0], 32'hAAAA_F0F0);
         chk("bp_order1", out_log[1], 32'd30);
         chk("bp_order2", out_log[2], 32'hFFFF_FFF6);
         chk("bp_order3", out_log[3], 32'd3);
      end
`else
      chk("bp_count", 32'(out_log.size()), 1);
      if (out_log.size() == 1) chk("bp_order0", out_log[0], 32'hAAAA_F0F0);
`endif
   endtask

   task automatic reset_mid();
      out_ready_i = 1'b1;
      send(ADD, 32'd100, 32'd23, 5'd4);
      @(posedge clk);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("rstmid_req", 32'(req_o), 0);
      chk("rstmid_valid", 32'(out_valid_o), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_ni = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("rstmid_no_stale", 32'(out_valid_o), 0);
      end
      @(posedge clk);
      #1;
      run_one(ADD, 32'd1, 32'd2, 5'd6, 32'd3, 1'b1, 1'b0, 32'd2);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      in_valid_i  = 1'b0;
      in_op_i     = ADD;
      in_a_i      = '0;
      in_b_i      = '0;
      in_rd_i     = '0;
      out_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_ni = 1'b1;

      run_one(ADD,  32'h7FFF_FFFF, 32'h1,  5'd5, 32'h8000_0000, 1'b1, 1'b0, 32'h1);
      run_one(SRA,  32'h8000_0000, 32'h24, 5'd3, 32'hF800_0000, 1'b1, 1'b0, 32'h4);
      run_one(SLTU, 32'h1,         32'h2,  5'd7, 32'h1,         1'b1, 1'b0, 32'h2);
      run_one(GE,   32'hFFFF_FFFF, 32'h0,  5'd9, 32'h0,         1'b0, 1'b0, 32'h0);
      run_one(SLL,  32'h1,         32'h3F, 5'd1, 32'h8000_0000, 1'b1, 1'b0, 32'h1F);
      run_one(EQ,   32'h5,         32'h5,  5'd2, 32'h0,         1'b0, 1'b1, 32'h5);
      run_one(SLT,  32'hFFFF_FFFF, 32'h1,  5'd8, 32'h1,         1'b1, 1'b0, 32'h1);

      backpressure();
      reset_mid();

      rand_ready = 1'b1;
      for (int n = 0; n < 300; n++) begin
         alu_op       op = alu_op'($urandom_range(0, 15));
         logic [31:0] a  = pick();
         logic [31:0] b  = ($urandom_range(0, 4) == 0) ? a : pick();
         send(op, a, b, 5'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1;
         end
      end
      rand_ready  = 1'b0;
      out_ready_i = 1'b1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
`default_nettype wire
